adxl_spi_sequencer: RTL and testbench

ADXL_SPI_SEQUENCER -- requirements
Module: adxl_spi_sequencer

---
 rtl/adxl_spi_sequencer.sv | 270 +++++++++++++++++++++++++++
 tb/tb_adxl_spi_sequencer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adxl_spi_sequencer.sv
// Command sequencer for an ADXL-style SPI accelerometer: soft-resets and configures the
// device, then periodically reads X/Y through a one-byte SPI engine and publishes block averages.
module adxl_spi_sequencer #(
  parameter int SYSCLK_FREQUENCY_HZ = 108_000_000,
  parameter int UPDATE_FREQUENCY_HZ = 100,
  parameter int NUM_READS_AVG       = 16,
  parameter int SS_GAP_CLKS         = 108,
  parameter int SRESET_WAIT_CLKS    = 54_000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        spi_start,
  output logic [7:0]  spi_tx_byte,
  input  logic        spi_done,
  input  logic [7:0]  spi_rx_byte,
  output logic        ss,
  output logic [11:0] accel_x,
  output logic [11:0] accel_y,
  output logic        data_rdy,
  output logic        cfg_done
);

  localparam int TICK_PERIOD = SYSCLK_FREQUENCY_HZ / (UPDATE_FREQUENCY_HZ * NUM_READS_AVG);
  localparam int AVG_SHIFT   = $clog2(NUM_READS_AVG);
  localparam int ACC_W       = 12 + AVG_SHIFT;
  localparam int TICK_W      = (TICK_PERIOD > 2) ? $clog2(TICK_PERIOD) : 1;
  localparam int WAIT_W      = (SRESET_WAIT_CLKS > 2) ? $clog2(SRESET_WAIT_CLKS) : 1;
  localparam int GAP_W       = (SS_GAP_CLKS > 1) ? $clog2(SS_GAP_CLKS + 1) : 1;
  localparam int CNT_W       = (AVG_SHIFT > 0) ? AVG_SHIFT : 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_PERIOD - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SRESET_WAIT_CLKS - 1);
  localparam logic [GAP_W-1:0]  GAP_MAX   = GAP_W'(SS_GAP_CLKS);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(NUM_READS_AVG - 1);

  typedef enum logic [2:0] {
    CFG_SRST,
    CFG_WAIT,
    CFG_MEAS,
    IDLE,
    READ,
    ACCUM
  } state_t;

  state_t state_q, state_d;
  logic              ss_q, ss_d;
  logic              spi_start_q, spi_start_d;
  logic [7:0]        tx_q, tx_d;
  logic [2:0]        byte_idx_q, byte_idx_d;
  logic              busy_q, busy_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic              pending_q, pending_d;
  logic [7:0]        xl_q, xl_d, yl_q, yl_d;
  logic [3:0]        xh_q, xh_d, yh_q, yh_d;
  logic signed [ACC_W-1:0] acc_x_q, acc_x_d, acc_y_q, acc_y_d;
  logic [CNT_W-1:0]  sample_cnt_q, sample_cnt_d;
  logic [11:0]       accel_x_q, accel_x_d, accel_y_q, accel_y_d;
  logic              data_rdy_q, data_rdy_d;
  logic              cfg_done_q, cfg_done_d;

  logic              tick;
  logic              gap_ok;
  logic              done_ok;
  logic [2:0]        last_idx;
  logic [11:0]       sample_x, sample_y;
  logic signed [ACC_W-1:0] sum_x, sum_y;

  // Command bytes of each transaction, indexed by position within the ss-low window.
  function automatic logic [7:0] seq_byte(input state_t st, input logic [2:0] idx);
    logic [7:0] b;
    b = 8'h00;
    case (st)
      CFG_SRST: b = (idx == 3'd0) ? 8'h0A : (idx == 3'd1) ? 8'h1F : 8'h52;
      CFG_MEAS: b = (idx == 3'd0) ? 8'h0A : (idx == 3'd1) ? 8'h2D : 8'h02;
      default:  b = (idx == 3'd0) ? 8'h0B : (idx == 3'd1) ? 8'h0E : 8'h00;
    endcase
    return b;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= CFG_SRST;
      ss_q         <= 1'b1;
      spi_start_q  <= 1'b0;
      tx_q         <= 8'h00;
      byte_idx_q   <= 3'd0;
      busy_q       <= 1'b0;
      wait_q       <= '0;
      gap_q        <= '0;
      tick_cnt_q   <= '0;
      pending_q    <= 1'b0;
      xl_q         <= 8'h00;
      xh_q         <= 4'h0;
      yl_q         <= 8'h00;
      yh_q         <= 4'h0;
      acc_x_q      <= '0;
      acc_y_q      <= '0;
      sample_cnt_q <= '0;
      accel_x_q    <= 12'h000;
      accel_y_q    <= 12'h000;
      data_rdy_q   <= 1'b0;
      cfg_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      ss_q         <= ss_d;
      spi_start_q  <= spi_start_d;
      tx_q         <= tx_d;
      byte_idx_q   <= byte_idx_d;
      busy_q       <= busy_d;
      wait_q       <= wait_d;
      gap_q        <= gap_d;
      tick_cnt_q   <= tick_cnt_d;
      pending_q    <= pending_d;
      xl_q         <= xl_d;
      xh_q         <= xh_d;
      yl_q         <= yl_d;
      yh_q         <= yh_d;
      acc_x_q      <= acc_x_d;
      acc_y_q      <= acc_y_d;
      sample_cnt_q <= sample_cnt_d;
      accel_x_q    <= accel_x_d;
      accel_y_q    <= accel_y_d;
      data_rdy_q   <= data_rdy_d;
      cfg_done_q   <= cfg_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    ss_d         = ss_q;
    spi_start_d  = 1'b0;
    tx_d         = tx_q;
    byte_idx_d   = byte_idx_q;
    busy_d       = busy_q;
    wait_d       = wait_q;
    gap_d        = gap_q;
    tick_cnt_d   = tick_cnt_q;
    pending_d    = pending_q;
    xl_d         = xl_q;
    xh_d         = xh_q;
    yl_d         = yl_q;
    yh_d         = yh_q;
    acc_x_d      = acc_x_q;
    acc_y_d      = acc_y_q;
    sample_cnt_d = sample_cnt_q;
    accel_x_d    = accel_x_q;
    accel_y_d    = accel_y_q;
    data_rdy_d   = 1'b0;
    cfg_done_d   = cfg_done_q;

    last_idx = (state_q == READ) ? 3'd5 : 3'd2;
    sample_x = {xh_q, xl_q};
    sample_y = {yh_q, yl_q};
    sum_x    = acc_x_q + {{AVG_SHIFT{sample_x[11]}}, sample_x};
    sum_y    = acc_y_q + {{AVG_SHIFT{sample_y[11]}}, sample_y};
    done_ok  = spi_done && busy_q;

    tick = cfg_done_q && (tick_cnt_q == TICK_LAST);
    if (cfg_done_q) begin
      tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    end

    // Saturating count of cycles since ss last rose.
    if (!ss_q) begin
      gap_d = '0;
    end else if (gap_q != GAP_MAX) begin
      gap_d = gap_q + 1'b1;
    end
    gap_ok = (gap_q == GAP_MAX);

    if (tick) begin
      pending_d = 1'b1;
    end

    case (state_q)
      CFG_SRST, CFG_MEAS, READ: begin
        if (ss_q) begin
          ss_d       = 1'b0;
          tx_d       = seq_byte(state_q, 3'd0);
          byte_idx_d = 3'd0;
        end else if (!busy_q) begin
          spi_start_d = 1'b1;
          busy_d      = 1'b1;
        end else if (done_ok) begin
          busy_d = 1'b0;
          if (state_q == READ) begin
            case (byte_idx_q)
              3'd2:    xl_d = spi_rx_byte;
              3'd3:    xh_d = spi_rx_byte[3:0];
              3'd4:    yl_d = spi_rx_byte;
              3'd5:    yh_d = spi_rx_byte[3:0];
              default: ;
            endcase
          end
          if (byte_idx_q == last_idx) begin
            ss_d       = 1'b1;
            byte_idx_d = 3'd0;
            case (state_q)
              CFG_SRST: begin
                state_d = CFG_WAIT;
                wait_d  = '0;
              end
              CFG_MEAS: begin
                state_d    = IDLE;
                cfg_done_d = 1'b1;
              end
              default:  state_d = ACCUM;
            endcase
          end else begin
            byte_idx_d  = byte_idx_q + 3'd1;
            tx_d        = seq_byte(state_q, byte_idx_q + 3'd1);
            spi_start_d = 1'b1;
            busy_d      = 1'b1;
          end
        end
      end

      CFG_WAIT: begin
        if (wait_q == WAIT_LAST) begin
          state_d    = CFG_MEAS;
          ss_d       = 1'b0;
          tx_d       = seq_byte(CFG_MEAS, 3'd0);
          byte_idx_d = 3'd0;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end

      IDLE: begin
        // A launch consumes the pending tick together with any tick arriving this cycle.
        if ((tick || pending_q) && gap_ok) begin
          state_d    = READ;
          ss_d       = 1'b0;
          tx_d       = seq_byte(READ, 3'd0);
          byte_idx_d = 3'd0;
          pending_d  = 1'b0;
        end
      end

      ACCUM: begin
        state_d = IDLE;
        if (sample_cnt_q == CNT_LAST) begin
          accel_x_d    = 12'(sum_x >>> AVG_SHIFT);
          accel_y_d    = 12'(sum_y >>> AVG_SHIFT);
          data_rdy_d   = 1'b1;
          acc_x_d      = '0;
          acc_y_d      = '0;
          sample_cnt_d = '0;
        end else begin
          acc_x_d      = sum_x;
          acc_y_d      = sum_y;
          sample_cnt_d = sample_cnt_q + 1'b1;
        end
      end

      default: state_d = CFG_SRST;
    endcase
  end

  assign spi_start   = spi_start_q;
  assign spi_tx_byte = tx_q;
  assign ss          = ss_q;
  assign accel_x     = accel_x_q;
  assign accel_y     = accel_y_q;
  assign data_rdy    = data_rdy_q;
  assign cfg_done    = cfg_done_q;

endmodule

// File: tb/tb_adxl_spi_sequencer.sv
// Directed bench for adxl_spi_sequencer with a 16-clock SPI byte-engine model.
module tb_adxl_spi_sequencer;

  localparam int GAP    = 20;
  localparam int SRST_W = 50;

  logic        clk;
  logic        rst;
  logic        spi_start;
  logic [7:0]  spi_tx_byte;
  logic        spi_done;
  logic [7:0]  spi_rx_byte;
  logic        ss;
  logic [11:0] accel_x;
  logic [11:0] accel_y;
  logic        data_rdy;
  logic        cfg_done;

  logic        spi_done_m;
  logic        spi_done_s;
  logic [7:0]  spi_rx_m;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Engine model state
  bit  eng_busy;
  int  eng_cnt;
  int  eng_idx;
  int  eng_pos;
  int  rd_num;
  int  eng_err;
  int  done_cyc;
  logic [7:0] eng_tx;

  // Monitor state
  logic [7:0] tx_log[$];
  int  gap_log[$];
  int  high_run;
  int  low_age;
  int  txn_starts;
  int  prot_err;
  int  drdy_cnt;
  int  drdy_hi;
  logic drdy_prev;
  logic [11:0] last_x;
  logic [11:0] last_y;

  logic [7:0] exp_cfg [0:5] = '{8'h0A, 8'h1F, 8'h52, 8'h0A, 8'h2D, 8'h02};
  logic [7:0] exp_rd  [0:5] = '{8'h0B, 8'h0E, 8'h00, 8'h00, 8'h00, 8'h00};

  assign spi_done    = spi_done_m | spi_done_s;
  assign spi_rx_byte = spi_done_s ? 8'hEE : spi_rx_m;

  adxl_spi_sequencer #(
    .SYSCLK_FREQUENCY_HZ(128_000),
    .UPDATE_FREQUENCY_HZ(100),
    .NUM_READS_AVG(16),
    .SS_GAP_CLKS(GAP),
    .SRESET_WAIT_CLKS(SRST_W)
  ) dut (
    .clk(clk),
    .reset(rst),
    .spi_start(spi_start),
    .spi_tx_byte(spi_tx_byte),
    .spi_done(spi_done),
    .spi_rx_byte(spi_rx_byte),
    .ss(ss),
    .accel_x(accel_x),
    .accel_y(accel_y),
    .data_rdy(data_rdy),
    .cfg_done(cfg_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Device register image per read: first 16 reads X=0x134 Y=0xFFF, then X alternates
  // 0x7FF/0x800 with Y=0x001 and junk in the unused high nibbles.
  function automatic logic [7:0] rx_for(input int p, input int rd);
    logic [11:0] x, y;
    logic [3:0]  xn, yn;
    logic [7:0]  b;
    if (rd < 16) begin
      x = 12'h134; y = 12'hFFF; xn = 4'h0; yn = 4'hF;
    end else begin
      x = (rd % 2 == 0) ? 12'h7FF : 12'h800; y = 12'h001; xn = 4'h5; yn = 4'h5;
    end
    case (p)
      2:       b = x[7:0];
      3:       b = {xn, x[11:8]};
      4:       b = y[7:0];
      5:       b = {yn, y[11:8]};
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_log(input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (tx_log.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 32'(tx_log.size() >= n), 32'd1);
  endtask

  // Byte engine: spi_done 16 clocks after each accepted spi_start.
  initial begin : engine
    spi_done_m = 1'b0; spi_rx_m = 8'h00; eng_busy = 0; eng_cnt = 0;
    eng_idx = 0; eng_pos = 0; rd_num = 0; eng_err = 0; done_cyc = 0; eng_tx = 8'h00;
    forever begin
      @(negedge clk);
      spi_done_m = 1'b0;
      if (rst) begin
        eng_busy = 0;
        eng_idx  = 0;
      end else begin
        if (ss) eng_idx = 0;
        if (spi_start && eng_busy) eng_err++;
        if (eng_busy && !spi_start && spi_tx_byte != eng_tx) eng_err++;
        if (eng_busy) begin
          eng_cnt--;
          if (eng_cnt == 0) begin
            spi_done_m = 1'b1;
            spi_rx_m   = rx_for(eng_pos, rd_num);
            eng_busy   = 0;
            done_cyc   = cyc;
            if (eng_pos == 5) rd_num++;
          end
        end
        if (spi_start && !eng_busy) begin
          eng_busy = 1;
          eng_cnt  = 16;
          eng_tx   = spi_tx_byte;
          eng_pos  = eng_idx;
          eng_idx++;
        end
      end
    end
  end

  // Transaction monitor: byte log, ss-high run lengths, ss/start ordering, data_rdy pulses.
  initial begin : monitor
    high_run = 0; low_age = 0; txn_starts = 0; prot_err = 0;
    drdy_cnt = 0; drdy_hi = 0; drdy_prev = 1'b0; last_x = '0; last_y = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        high_run = 0; low_age = 0; txn_starts = 0;
      end else begin
        if (ss) begin
          high_run++;
          low_age = 0;
          txn_starts = 0;
        end else begin
          if (low_age == 0) gap_log.push_back(high_run);
          high_run = 0;
          low_age++;
        end
        if (spi_start) begin
          tx_log.push_back(spi_tx_byte);
          if (ss) prot_err++;
          if (txn_starts == 0 && low_age != 2) prot_err++;
          txn_starts++;
        end
      end
      if (data_rdy) begin
        drdy_hi++;
        if (!drdy_prev) begin
          drdy_cnt++;
          last_x = accel_x;
          last_y = accel_y;
          $display("data_rdy #%0d accel_x=0x%03h accel_y=0x%03h", drdy_cnt, accel_x, accel_y);
        end
      end
      drdy_prev = data_rdy;
    end
  end

  initial begin : main
    int k;
    int n;
    int base;
    int gmin;
    int gmax;
    rst = 1'b1;
    spi_done_s = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_ss", 32'(ss), 32'd1);
    chk("rst_spi_start", 32'(spi_start), 32'd0);
    chk("rst_tx_byte", 32'(spi_tx_byte), 32'h00);
    chk("rst_accel", {8'h00, accel_x, accel_y}, 32'h0);
    chk("rst_data_rdy", 32'(data_rdy), 32'd0);
    chk("rst_cfg_done", 32'(cfg_done), 32'd0);

    rst = 1'b0;
    wait_log(6, 600, "cfg_bytes_seen");
    for (int i = 0; i < 6; i++) chk($sformatf("cfg_byte%0d", i), 32'(tx_log[i]), 32'(exp_cfg[i]));
    chk("cfg_wait_ss_high", 32'(gap_log[1]), 32'(SRST_W));

    k = 0;
    while (!cfg_done && k < 200) begin @(negedge clk); k++; end
    chk("cfg_done_high", 32'(cfg_done), 32'd1);
    chk("cfg_done_latency", 32'(cyc - done_cyc), 32'd1);
    chk("cfg_end_ss_high", 32'(ss), 32'd1);

    wait_log(12, 600, "read_bytes_seen");
    for (int i = 0; i < 6; i++) chk($sformatf("read_byte%0d", i), 32'(tx_log[6 + i]), 32'(exp_rd[i]));

    k = 0;
    while (drdy_cnt < 1 && k < 5000) begin @(negedge clk); k++; end
    chk("avg1_accel_x", 32'(last_x), 32'h134);
    chk("avg1_accel_y", 32'(last_y), 32'hFFF);

    // Spurious engine pulses while the sequencer is idle between reads.
    k = 0;
    while (ss && k < 400) begin @(negedge clk); k++; end
    while (!ss && k < 800) begin @(negedge clk); k++; end
    chk("spurious_window", 32'(ss), 32'd1);
    base = tx_log.size();
    for (int i = 0; i < 3; i++) begin
      spi_done_s = 1'b1;
      @(negedge clk);
      spi_done_s = 1'b0;
      chk($sformatf("spurious_idle%0d", i), {30'd0, ss, spi_start}, 32'h2);
    end
    chk("spurious_no_start", 32'(tx_log.size() - base), 32'd0);

    k = 0;
    while (drdy_cnt < 2 && k < 5000) begin @(negedge clk); k++; end
    chk("avg2_accel_x", 32'(last_x), 32'hFFF);
    chk("avg2_accel_y", 32'(last_y), 32'h001);
    @(negedge clk);
    chk("data_rdy_width", 32'(drdy_hi), 32'd2);

    gmin = 1_000_000;
    gmax = 0;
    for (int i = 3; i < gap_log.size(); i++) begin
      if (gap_log[i] < gmin) gmin = gap_log[i];
      if (gap_log[i] > gmax) gmax = gap_log[i];
    end
    chk("gap_min_ge_ss_gap", 32'(gmin >= GAP), 32'd1);
    chk("gap_max_pending_read", 32'(gmax <= GAP + 3), 32'd1);
    chk("protocol_errors", 32'(eng_err + prot_err), 32'd0);

    // Reset during the 4th byte of a READ.
    k = 0;
    while (ss && k < 400) begin @(negedge clk); k++; end
    n = 0;
    while (n < 4 && k < 800) begin
      @(negedge clk);
      k++;
      if (spi_start) n++;
    end
    chk("read_4th_start", 32'(n), 32'd4);
    chk("read_4th_tx_byte", 32'(spi_tx_byte), 32'h00);
    rst = 1'b1;
    #1;
    chk("abort_ss", 32'(ss), 32'd1);
    chk("abort_outputs", {10'd0, spi_start, data_rdy, cfg_done, spi_tx_byte, 1'b0}, 32'h0);
    chk("abort_accel", {8'h00, accel_x, accel_y}, 32'h0);
    repeat (2) @(negedge clk);
    base = tx_log.size();
    rst = 1'b0;
    wait_log(base + 3, 300, "restart_bytes_seen");
    for (int i = 0; i < 3; i++) chk($sformatf("restart_byte%0d", i), 32'(tx_log[base + i]), 32'(exp_cfg[i]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
